// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampled UART receiver: FSM encoding, tick and bit constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } rx_state_t;

    // Even-parity bit for a data byte (the bit that makes the total count of ones even).
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with count-derived status flags, flush and overrun pulse.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             data_present,
    output logic             half_full,
    output logic             full,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overrun;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && (r_count != ZERO_CNT);
    assign w_push_ok = push && ((r_count != FULL_CNT) || w_pop_ok);

    // Pointer, count and overrun bookkeeping; flush discards any same-cycle push.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr  <= AW'(0);
            r_rd_ptr  <= AW'(0);
            r_count   <= ZERO_CNT;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_overrun <= push && !w_push_ok;
        end
    end

    // Storage array; no reset because the head is masked while empty.
    always_ff @(posedge clock) begin
        if (w_push_ok && !flush && !reset) r_mem[r_wr_ptr] <= push_data;
    end

    assign data_present = (r_count != ZERO_CNT);
    assign half_full    = (r_count >= HALF_CNT);
    assign full         = (r_count == FULL_CNT);
    assign overrun      = r_overrun;
    assign head         = data_present ? r_mem[r_rd_ptr] : WIDTH'(0);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled 8-bit UART receiver feeding a FWFT FIFO; reports framing errors and overruns.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_error pulse output (default 8N1).
module uart_rx_oversampled
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       en_16_x_baud,
    input  logic       read_buffer,
    input  logic       reset_buffer,
    output logic [7:0] data_out,
    output logic       buffer_data_present,
    output logic       buffer_half_full,
    output logic       buffer_full,
    output logic       framing_error,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);
    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [3:0]             r_tick;
    logic [3:0]             w_tick_next;
    logic [2:0]             r_bit;
    logic [2:0]             w_bit_next;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_next;
    logic                   r_frame_err;
    logic                   w_frame_err;
    logic                   w_push;
    logic                   w_rxs;
    logic                   w_sample;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_err;
    logic                   w_par_err;
    logic                   r_par_bad;
    logic                   w_par_bad_next;
`endif

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    assign w_sample = en_16_x_baud && (r_tick == LAST_TICK);

    // Line synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) r_sync <= {SYNC_STAGES{1'b1}};
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tick      <= 4'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_par_err;
            r_par_bad   <= w_par_bad_next;
`endif
        end
    end

    // Next-state logic; the tick counter free-runs on enables and wraps 15->0 between bits.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = en_16_x_baud ? r_tick + 4'd1 : r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_frame_err  = 1'b0;
        w_push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err      = 1'b0;
        w_par_bad_next = r_par_bad;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tick_next = 4'd0;
                if (en_16_x_baud && !w_rxs) w_state_next = ST_START;
                else                        w_state_next = ST_IDLE;
            end
            ST_START: begin
                if (en_16_x_baud && (r_tick == MID_TICK)) begin
                    w_tick_next = 4'd0;
                    w_bit_next  = 3'd0;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_next = 1'b0;
`endif
                    w_state_next = w_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    w_shift_next = {w_rxs, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                    w_state_next = (r_bit == LAST_BIT) ? ST_PARITY : ST_DATA;
`else
                    w_state_next = (r_bit == LAST_BIT) ? ST_STOP : ST_DATA;
`endif
                end else begin
                    w_state_next = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_sample) begin
                    w_par_err      = (w_rxs != even_parity(r_shift));
                    w_par_bad_next = w_par_err;
                    w_state_next   = ST_STOP;
                end else begin
                    w_state_next = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (w_sample) begin
`ifdef UART_RX_PARITY_EN
                    w_push = w_rxs && !r_par_bad;
`else
                    w_push = w_rxs;
`endif
                    w_frame_err  = !w_rxs;
                    w_state_next = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rxs) w_state_next = ST_IDLE;
                else       w_state_next = ST_WAIT_HIGH;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .flush        (reset_buffer),
        .push         (w_push),
        .push_data    (w_shift_next),
        .pop          (read_buffer),
        .head         (data_out),
        .data_present (buffer_data_present),
        .half_full    (buffer_half_full),
        .full         (buffer_full),
        .overrun      (overrun)
    );

    assign framing_error = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_par_err;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames are driven bit by bit, expected bytes queued
// and compared as the FIFO is read. Parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversampled;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       en_16_x_baud = 1'b0;
    logic       read_buffer = 1'b0;
    logic       reset_buffer = 1'b0;
    logic [7:0] w_data_out;
    logic       w_present, w_half, w_full, w_fe, w_ov;
`ifdef UART_RX_PARITY_EN
    logic       w_pe;
    int         pe_seen = 0;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;
    int         tick_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_oversampled #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clock               (clock),
        .reset               (reset),
        .serial_in           (serial_in),
        .en_16_x_baud        (en_16_x_baud),
        .read_buffer         (read_buffer),
        .reset_buffer        (reset_buffer),
        .data_out            (w_data_out),
        .buffer_data_present (w_present),
        .buffer_half_full    (w_half),
        .buffer_full         (w_full),
        .framing_error       (w_fe),
        .overrun             (w_ov)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error        (w_pe)
`endif
    );

    always #5 clock = ~clock;

    // Baud enable: one-clock pulse every TICK_DIV clocks.
    always @(negedge clock) begin
        if (tick_cnt == TICK_DIV - 1) begin
            en_16_x_baud = 1'b1;
            tick_cnt     = 0;
        end else begin
            en_16_x_baud = 1'b0;
            tick_cnt     = tick_cnt + 1;
        end
    end

    // Error pulse counters.
    always @(negedge clock) begin
        if (w_fe === 1'b1) fe_seen++;
        if (w_ov === 1'b1) ov_seen++;
`ifdef UART_RX_PARITY_EN
        if (w_pe === 1'b1) pe_seen++;
`endif
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    // Full frame; with chk_t the FIFO must be empty before the stop-bit centre and filled after it.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic chk_t);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        serial_in = stop_b;
        repeat (BIT_CLKS / 4) @(negedge clock);
        if (chk_t) check("no_early_push", w_present, 1'b0);
        repeat (BIT_CLKS - BIT_CLKS / 4) @(negedge clock);
        if (chk_t) check("push_after_stop", w_present, 1'b1);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, 1'b0);
    endtask

    task automatic pop_check();
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_present", w_present, 1'b1);
        check("pop_data", w_data_out, e);
        read_buffer = 1'b1;
        @(negedge clock);
        read_buffer = 1'b0;
    endtask

    initial begin
        int fe0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        check("rst_present", w_present, 1'b0);
        check("rst_half", w_half, 1'b0);
        check("rst_full", w_full, 1'b0);
        check("rst_fe", w_fe, 1'b0);
        check("rst_ov", w_ov, 1'b0);
        check("rst_data", w_data_out, 8'h00);
        repeat (BIT_CLKS) @(negedge clock);

        // Basic frame with stop-sample timing, then read drains the FIFO.
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b1);
        pop_check();
        check("empty_after_read", w_present, 1'b0);
        read_buffer = 1'b1;
        @(negedge clock);
        read_buffer = 1'b0;
        check("read_empty_noop", w_present, 1'b0);

        // Short low glitch is rejected.
        serial_in = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clock);
        serial_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        check("glitch_no_push", w_present, 1'b0);
        check("glitch_no_fe", fe_seen, 0);
        send_good(8'hA5);
        pop_check();

        // Bad stop bit, then a long break, then recovery.
        send_frame(8'h55, 1'b0, 1'b0);
        check("fe_pulse", fe_seen, 1);
        check("fe_no_push", w_present, 1'b0);
        repeat (20 * BIT_CLKS) @(negedge clock);
        check("break_no_fe", fe_seen, 1);
        check("break_no_push", w_present, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_good(8'h3C);
        pop_check();

        // Fill to full, overrun on the 17th byte, then drain in order.
        for (int k = 0; k < 16; k++) begin
            send_good(8'(k));
            check("half_flag", w_half, (k + 1 >= 8) ? 1'b1 : 1'b0);
            check("full_flag", w_full, (k + 1 >= 16) ? 1'b1 : 1'b0);
        end
        check("ov_none_yet", ov_seen, 0);
        send_frame(8'h10, 1'b1, 1'b0);
        check("ov_pulse", ov_seen, 1);
        check("ov_still_full", w_full, 1'b1);
        for (int k = 0; k < 16; k++) pop_check();
        check("drained", w_present, 1'b0);
        check("drained_fe", fe_seen, 1);

        // Flush discards buffered data.
        send_good(8'h12);
        check("pre_flush", w_present, 1'b1);
        reset_buffer = 1'b1;
        @(negedge clock);
        reset_buffer = 1'b0;
        exp_q.delete();
        check("flush_empty", w_present, 1'b0);

        // Reset during bit 7 of 0x81 with a byte already buffered.
        send_good(8'h99);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(1'(8'h81 >> i));
        serial_in = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_present", w_present, 1'b0);
        check("mid_rst_half", w_half, 1'b0);
        check("mid_rst_full", w_full, 1'b0);
        check("mid_rst_fe", w_fe, 1'b0);
        check("mid_rst_ov", w_ov, 1'b0);
        check("mid_rst_data", w_data_out, 8'h00);
        repeat (3 * BIT_CLKS) @(negedge clock);
        send_good(8'h7E);
        pop_check();
        check("end_empty", w_present, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Correct parity accepted; flipped parity pulses parity_error and is dropped.
        send_good(8'h07);
        pop_check();
        fe0 = fe_seen;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'(8'h07 >> i));
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("pe_pulse", pe_seen, 1);
        check("pe_no_push", w_present, 1'b0);
        check("pe_no_fe", fe_seen, fe0);
`else
        fe0 = fe_seen;
        check("fe_total", fe0, 1);
`endif

        repeat (BIT_CLKS) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
